// File: rtl/alu_seq_if.sv
// Command/response handshake bundle between a command source and alu_seq.
// The source side uses master; the sequencer side uses slave.
interface alu_seq_if #(
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs;
  logic [AW-1:0] cmd_rt;
  logic          cmd_imm_en;
  logic [31:0]   cmd_imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rsp_rd;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs,
    output cmd_rt, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs,
    input  cmd_rt, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_seq.sv
// Command sequencer for a combinational alu: fetches operands from a
// small register file, runs one op per command, writes back and responds.
module alu_seq #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_if.slave      bus,
  output logic [31:0]   alu_A,
  output logic [31:0]   alu_B,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_C,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state, state_d;
  logic [31:0]   regs [NREG];
  logic [AW-1:0] rd_q;
  logic [31:0]   op_a;
  logic [31:0]   op_b;

  function automatic logic [31:0] rd_reg(
    input logic [AW-1:0] i
  );
    return (i == '0) ? 32'd0 : regs[i];
  endfunction

  assign op_a     = rd_reg(bus.cmd_rs);
  assign op_b     = bus.cmd_imm_en ? bus.cmd_imm
                                   : rd_reg(bus.cmd_rt);
  assign dbg_data = rd_reg(dbg_addr);

  always_comb begin
    state_d       = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_q         <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= '0;
      bus.rsp_data <= '0;
      bus.rsp_rd   <= '0;
      bus.rsp_err  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.cmd_valid) begin
        alu_A  <= op_a;
        alu_B  <= op_b;
        alu_op <= bus.cmd_op;
        rd_q   <= bus.cmd_rd;
      end
      // alu_C is only meaningful while the latched operands sit on the alu
      if (state == EXEC) begin
        bus.rsp_data <= alu_C;
        bus.rsp_rd   <= rd_q;
        bus.rsp_err  <= (alu_op[2:1] == 2'b11);
        if (rd_q != '0) regs[rd_q] <= alu_C;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq with an in-bench alu and a
// behavioural register-file model driving a per-cycle response checker.
module tb_alu_seq;

  localparam int AW = 3;
  localparam int NREG = 8;

  logic          clk = 0;
  logic          reset = 1;
  logic [31:0]   alu_A, alu_B, alu_C;
  logic [2:0]    alu_op;
  logic [AW-1:0] dbg_addr = 0;
  logic [31:0]   dbg_data;

  alu_seq_if #(.AW(AW)) bus ();

  alu_seq #(.NREG(NREG), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_op   (alu_op),
    .alu_C    (alu_C),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // combinational alu the sequencer drives
  always_comb begin
    alu_C = 32'd0;
    case (alu_op)
      3'd0: alu_C = alu_A + alu_B;
      3'd1: alu_C = alu_A - alu_B;
      3'd2: alu_C = alu_A & alu_B;
      3'd3: alu_C = alu_A | alu_B;
      3'd4: alu_C = (alu_B > 32'd31) ? 32'd0 : alu_A >> alu_B[4:0];
      3'd5: alu_C = (alu_B > 32'd31) ? {32{alu_A[31]}}
                  : 32'($signed(alu_A) >>> alu_B[4:0]);
      default: alu_C = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] rd;
    logic          err;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mregs [NREG];
  exp_t        exp_q [$];
  bit          busy = 0;
  int          age = 0;
  bit          rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sx;
    sx = {{32{a[31]}}, a};
    case (op)
      3'd0: return a + b;
      3'd1: return a + (~b) + 32'd1;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b >= 32) ? 32'd0 : 32'(64'(a) / (64'd1 << b));
      3'd5: return (b >= 32) ? (a[31] ? 32'hFFFF_FFFF : 32'd0)
                            : sx[b[4:0] +: 32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mget(input logic [AW-1:0] i);
    return (i == 0) ? 32'd0 : mregs[i];
  endfunction

  // expected handshake timing: response one cycle after acceptance
  always @(posedge clk) begin
    if (reset) begin
      busy = 0;
      age = 0;
      exp_q.delete();
    end else if (busy) begin
      if (age >= 1 && bus.rsp_ready) begin
        busy = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        age++;
      end
    end else if (bus.cmd_valid) begin
      busy = 1;
      age = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(busy && age >= 1));
      if (busy && age >= 1) begin
        if (exp_q.size() == 0) begin
          chk("rsp_queue_empty", 32'd1, 32'd0);
        end else begin
          chk("rsp_data", bus.rsp_data, exp_q[0].data);
          chk("rsp_rd", 32'(bus.rsp_rd), 32'(exp_q[0].rd));
          chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.rsp_ready = ($urandom % 3) != 0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic ie, input logic [31:0] imm);
    int n;
    logic [31:0] a, b, c;
    exp_t e;
    @(posedge clk);
    #1;
    bus.cmd_op = op;
    bus.cmd_rd = rd;
    bus.cmd_rs = rs;
    bus.cmd_rt = rt;
    bus.cmd_imm_en = ie;
    bus.cmd_imm = imm;
    bus.cmd_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && !bus.cmd_ready && n < 60 ||
               busy && n < 60);
    if (n >= 60) begin
      chk("cmd_accept_timeout", 32'd1, 32'd0);
      bus.cmd_valid = 0;
      return;
    end
    a = mget(rs);
    b = ie ? imm : mget(rt);
    c = ref_alu(op, a, b);
    e.data = c;
    e.rd = rd;
    e.err = (op >= 3'd6);
    exp_q.push_back(e);
    if (rd != 0) mregs[rd] = c;
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic dbg_chk(input string name, input logic [AW-1:0] idx,
                         input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic do_reset();
    reset = 1;
    for (int i = 0; i < NREG; i++) mregs[i] = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
  endtask

  initial begin
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_rd = 0;
    bus.cmd_rs = 0;
    bus.cmd_rt = 0;
    bus.cmd_imm_en = 0;
    bus.cmd_imm = 0;
    bus.rsp_ready = 1;
    do_reset();

    for (int i = 1; i < NREG; i++) dbg_chk("reset_reg", AW'(i), 32'd0);
    #1;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    send(3'd0, 3'd1, 3'd0, 3'd0, 1, 32'd5);
    send(3'd0, 3'd2, 3'd1, 3'd1, 0, 32'd0);
    wait_idle();
    dbg_chk("r1_add_imm", 3'd1, 32'd5);
    dbg_chk("r2_add_reg", 3'd2, 32'd10);

    send(3'd0, 3'd3, 3'd0, 3'd0, 1, 32'h8000_0000);
    send(3'd1, 3'd4, 3'd0, 3'd3, 0, 32'd0);
    send(3'd5, 3'd5, 3'd3, 3'd0, 1, 32'd4);
    send(3'd4, 3'd7, 3'd3, 3'd0, 1, 32'd32);
    wait_idle();
    dbg_chk("r4_sub_wrap", 3'd4, 32'h8000_0000);
    dbg_chk("r5_sra", 3'd5, 32'hF800_0000);
    dbg_chk("r7_srl32", 3'd7, 32'd0);

    bus.rsp_ready = 0;
    send(3'd0, 3'd7, 3'd2, 3'd0, 1, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.cmd_op = 3'd0;
        bus.cmd_rd = 3'd1;
        bus.cmd_rs = 3'd0;
        bus.cmd_imm_en = 1;
        bus.cmd_imm = 32'd999;
        bus.cmd_valid = 1;
      end
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'd11);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.cmd_valid = 0;
    end
    bus.rsp_ready = 1;
    wait_idle();
    dbg_chk("bp_pulse_ignored", 3'd1, 32'd5);

    send(3'd0, 3'd6, 3'd0, 3'd0, 1, 32'd77);
    send(3'd7, 3'd6, 3'd1, 3'd0, 1, 32'd3);
    send(3'd0, 3'd0, 3'd1, 3'd0, 1, 32'd1);
    wait_idle();
    dbg_chk("r6_invalid_op", 3'd6, 32'd0);
    dbg_chk("r0_stays_zero", 3'd0, 32'd0);

    send(3'd0, 3'd1, 3'd0, 3'd0, 1, 32'd42);
    reset = 1;
    for (int i = 0; i < NREG; i++) mregs[i] = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    dbg_chk("rst_drop_wb", 3'd1, 32'd0);
    send(3'd0, 3'd2, 3'd0, 3'd0, 1, 32'd9);
    wait_idle();
    dbg_chk("post_rst_cmd", 3'd2, 32'd9);

    rand_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] imm;
      imm = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
      repeat ($urandom % 3) @(posedge clk);
      send(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
           1'($urandom), imm);
    end
    wait_idle();
    rand_rdy = 0;
    bus.rsp_ready = 1;
    for (int i = 0; i < NREG; i++) dbg_chk("final_reg", AW'(i), mget(AW'(i)));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
